// File: rtl/bound_flasher_observer.sv
// bound_flasher_observer: decodes the LED bar into level/direction, flags turn-arounds and bad codes, and drives flick.
// Ports: clk, rst_n (async, active-low); LED bar in; trig_en/trig_level/trig_dir set when flick fires; err_clr clears err;
// flick out to the flasher; level, dir, peak, valley, turn_level, cycle_cnt and sticky err describe the observed bar.
module bound_flasher_observer #(
  parameter int N_LED     = 16,
  parameter int LVL_W     = 5,
  parameter int FLICK_LEN = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_LED-1:0] LED,
  input  logic             trig_en,
  input  logic [LVL_W-1:0] trig_level,
  input  logic             trig_dir,
  input  logic             err_clr,
  output logic             flick,
  output logic [LVL_W-1:0] level,
  output logic [1:0]       dir,
  output logic             peak,
  output logic             valley,
  output logic [LVL_W-1:0] turn_level,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [1:0]       err
);
  localparam int FC_W = (FLICK_LEN > 1) ? $clog2(FLICK_LEN) : 1;
  typedef enum logic [1:0] {IDLE = 2'b00, UP = 2'b01, DOWN = 2'b10} state_t;
  state_t state, state_nxt;
  logic [LVL_W-1:0] k, level_nxt;
  logic [FC_W-1:0] fcnt;
  logic legal, rise, fall, step_err, peak_nxt, valley_nxt, cnt_inc, fire, armed;
  assign dir = state;
  always_comb begin
    // a thermometer code plus one has no bit in common with itself
    legal = (LED & (LED + N_LED'(1))) == '0;
    k = '0;
    for (int i = 0; i < N_LED; i++) k = k + LVL_W'(LED[i]);
    rise = k > level;
    fall = k < level;
    step_err = legal && (rise ? (k - level) > LVL_W'(1) : (level - k) > LVL_W'(1));
    state_nxt = state;
    peak_nxt = 1'b0;
    valley_nxt = 1'b0;
    cnt_inc = 1'b0;
    if (legal)
      case (state)
        IDLE: state_nxt = rise ? UP : IDLE;
        UP: if (fall) begin
          state_nxt = DOWN;
          peak_nxt = 1'b1;
        end
        DOWN: if (rise) begin
          state_nxt = UP;
          valley_nxt = 1'b1;
        end else if (k == '0) begin
          state_nxt = IDLE;
          cnt_inc = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    level_nxt = legal ? k : level;
    fire = legal && trig_en && armed && !flick && k == trig_level && state_nxt == (trig_dir ? UP : DOWN);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      level <= '0;
      peak <= 1'b0;
      valley <= 1'b0;
      turn_level <= '0;
      cycle_cnt <= '0;
      err <= 2'b00;
      flick <= 1'b0;
      fcnt <= '0;
      armed <= 1'b1;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      peak <= peak_nxt;
      valley <= valley_nxt;
      if (peak_nxt || valley_nxt) turn_level <= level;
      if (cnt_inc && cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
      err <= (err_clr ? 2'b00 : err) | {step_err, !legal};
      // fcnt holds the cycles of the pulse still to come after the current one
      if (fire) begin
        flick <= 1'b1;
        fcnt <= FC_W'(FLICK_LEN - 1);
      end else if (flick) begin
        flick <= fcnt != '0;
        fcnt <= (fcnt != '0) ? fcnt - FC_W'(1) : fcnt;
      end
      armed <= fire ? 1'b0 : (!trig_en || level_nxt != trig_level) ? 1'b1 : armed;
    end
  end
endmodule

// File: tb/tb_bound_flasher_observer.sv
// tb_bound_flasher_observer: directed and random stimulus checked every cycle against a behavioural model.
module tb_bound_flasher_observer;
  localparam int FLICK_LEN = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] LED = 16'hFFFF;
  logic trig_en = 1'b0, trig_dir = 1'b0, err_clr = 1'b0;
  logic [4:0] trig_level = '0;
  logic flick, peak, valley;
  logic [4:0] level, turn_level;
  logic [1:0] dir, err;
  logic [7:0] cycle_cnt;
  int n_chk = 0, n_pass = 0;
  int m_level = 0, m_mode = 0, m_turn = 0, m_cycles = 0, m_left = 0;
  bit m_peak = 0, m_valley = 0, m_armed = 1;
  bit [1:0] m_err = 0;

  bound_flasher_observer #(.N_LED(16), .LVL_W(5), .FLICK_LEN(FLICK_LEN), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .LED(LED), .trig_en(trig_en), .trig_level(trig_level),
    .trig_dir(trig_dir), .err_clr(err_clr), .flick(flick), .level(level), .dir(dir),
    .peak(peak), .valley(valley), .turn_level(turn_level), .cycle_cnt(cycle_cnt), .err(err));

  always #5 clk = ~clk;

  function automatic int code_level(input logic [15:0] v);
    for (int j = 0; j <= 16; j++) if (v == 16'((32'd1 << j) - 1)) return j;
    return -1;
  endfunction

  function automatic logic [15:0] bar(input int n);
    return 16'((32'd1 << n) - 1);
  endfunction

  // model: mode 0 = idle, 1 = rising, 2 = falling; m_left = flick cycles still to show
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_level = 0; m_mode = 0; m_turn = 0; m_cycles = 0; m_left = 0;
      m_peak = 0; m_valley = 0; m_armed = 1; m_err = 0;
    end else begin
      int kk, prev;
      bit fire, was_on;
      kk = code_level(LED);
      prev = m_level;
      was_on = m_left > 0;
      fire = 0;
      m_peak = 0;
      m_valley = 0;
      if (err_clr) m_err = 0;
      if (kk < 0) m_err[0] = 1;
      else begin
        if (kk - prev > 1 || prev - kk > 1) m_err[1] = 1;
        if (kk > prev) begin
          if (m_mode == 2) begin m_valley = 1; m_turn = prev; end
          m_mode = 1;
        end else if (m_mode == 1 && kk < prev) begin
          m_peak = 1; m_turn = prev; m_mode = 2;
        end else if (m_mode == 2 && kk == 0) begin
          m_mode = 0;
          if (m_cycles < 255) m_cycles++;
        end
        m_level = kk;
        fire = trig_en && m_armed && !was_on && kk == int'(trig_level) && (trig_dir ? m_mode == 1 : m_mode == 2);
      end
      if (fire) begin
        m_left = FLICK_LEN;
        m_armed = 0;
      end else begin
        if (m_left > 0) m_left--;
        if (!trig_en || m_level != int'(trig_level)) m_armed = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) if (rst_n) begin
    chk("m_flick", 32'(flick), 32'(m_left > 0));
    chk("m_level", 32'(level), m_level);
    chk("m_dir", 32'(dir), m_mode);
    chk("m_peak", 32'(peak), 32'(m_peak));
    chk("m_valley", 32'(valley), 32'(m_valley));
    chk("m_turn", 32'(turn_level), m_turn);
    chk("m_cycles", 32'(cycle_cnt), m_cycles);
    chk("m_err", 32'(err), 32'(m_err));
  end

  task automatic step(input logic [15:0] v);
    LED = v;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    LED = 16'hFFFF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(16'h0000);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_flick", 32'(flick), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_dir", 32'(dir), 0);
    chk("rst_pv", 32'({peak, valley}), 0);
    chk("rst_turn", 32'(turn_level), 0);
    chk("rst_cnt", 32'(cycle_cnt), 0);
    chk("rst_err", 32'(err), 0);
    rst_n = 1'b1;
    step(16'h0000);
    chk("idle_level", 32'(level), 0);
    chk("idle_dir", 32'(dir), 0);
    for (int i = 1; i <= 6; i++) step(bar(i));
    chk("ramp_top", 32'(level), 6);
    chk("ramp_up_dir", 32'(dir), 1);
    step(bar(5));
    chk("ramp_peak", 32'(peak), 1);
    chk("ramp_turn", 32'(turn_level), 6);
    chk("ramp_down_dir", 32'(dir), 2);
    for (int i = 4; i >= 0; i--) step(bar(i));
    chk("ramp_cnt", 32'(cycle_cnt), 1);
    chk("ramp_end_dir", 32'(dir), 0);
    chk("ramp_err", 32'(err), 0);

    do_reset();
    step(16'h001F);
    step(16'h0000);
    chk("kb_peak5", 32'({peak, turn_level}), 32'h25);
    step(16'h03FF);
    chk("kb_valley0", 32'({valley, turn_level}), 32'h20);
    step(16'h001F);
    chk("kb_peak10", 32'({peak, turn_level}), 32'h2A);
    step(16'hFFFF);
    chk("kb_valley5", 32'({valley, turn_level}), 32'h25);
    step(16'h0000);
    chk("kb_peak16", 32'({peak, turn_level}), 32'h30);
    step(16'h0000);
    chk("kb_cnt", 32'(cycle_cnt), 1);

    do_reset();
    step(16'h0005);
    chk("err_illegal", 32'(err), 1);
    chk("err_hold", 32'(level), 0);
    step(16'h0001);
    step(16'h0003);
    step(16'h000F);
    chk("err_jump", 32'(err), 3);
    chk("err_jump_lvl", 32'(level), 4);
    err_clr = 1'b1;
    step(16'h0005);
    chk("err_setwins", 32'(err), 1);
    step(16'h000F);
    chk("err_clr", 32'(err), 0);
    err_clr = 1'b0;

    do_reset();
    trig_en = 1'b1;
    trig_level = 5'd5;
    trig_dir = 1'b1;
    for (int i = 1; i <= 4; i++) step(bar(i));
    chk("trg_quiet", 32'(flick), 0);
    step(bar(5));
    chk("trg_fire1", 32'(flick), 1);
    step(bar(6));
    chk("trg_hold1", 32'(flick), 1);
    step(bar(7));
    chk("trg_end1", 32'(flick), 0);
    step(bar(8));
    for (int i = 7; i >= 0; i--) begin
      step(bar(i));
      chk("trg_fall", 32'(flick), 0);
    end
    step(16'h0000);
    for (int i = 1; i <= 5; i++) step(bar(i));
    chk("trg_fire2", 32'(flick), 1);
    #2 rst_n = 1'b0;
    #1 chk("trg_rst_kill", 32'(flick), 0);
    @(negedge clk);
    rst_n = 1'b1;
    trig_en = 1'b0;
    step(16'h0000);
    chk("post_rst_cnt", 32'(cycle_cnt), 0);
    chk("post_rst_level", 32'(level), 0);

    begin
      int nk = 0, wd = 1;
      for (int n = 0; n < 4000; n++) begin
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 5) LED = 16'($urandom);
        else begin
          if (r < 12) nk = int'($urandom_range(0, 16));
          else begin
            if ($urandom_range(0, 9) == 0) wd = -wd;
            if (nk + wd > 16 || nk + wd < 0) wd = -wd;
            if ($urandom_range(0, 4) != 0) nk = nk + wd;
          end
          LED = bar(nk);
        end
        if ($urandom_range(0, 29) == 0) trig_en = ~trig_en;
        if ($urandom_range(0, 49) == 0) begin
          trig_level = 5'($urandom_range(0, 16));
          trig_dir = 1'($urandom);
        end
        err_clr = $urandom_range(0, 9) == 0;
        @(negedge clk);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
